// File: rtl/audio_pkg.sv
// audio_pkg: definitions shared by the codec audio path blocks.
//   AUDIO_SAMPLE_W : default bits per channel sample
//   dac_state_t    : DAC serializer frame-tracking states
//   edge_ev_t      : rise/fall event pair from a synchronized pin
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,  // not yet aligned to a left-channel frame
    WAIT_MSB  = 2'd1,  // I2S one-bit delay slot after an LR edge
    SHIFT     = 2'd2,  // shifting sample bits MSB-first
    PAD       = 2'd3   // sample done, zeros until the next LR edge
  } dac_state_t;

endpackage

// File: rtl/audio_dac_transmitter_edge_sync.sv
// edge_sync: brings an asynchronous codec clock pin into the clk domain
// and produces single-cycle, registered rise/fall event pulses.
//   clk   : system clock
//   reset : synchronous active-high reset (all flops to 0)
//   pin   : asynchronous input pin
//   rise  : one-cycle pulse, 3 clk cycles after a pin 0->1 edge
//   fall  : one-cycle pulse, 3 clk cycles after a pin 1->0 edge
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic sync_1;
  logic sync_2;
  logic prev;

  // sync_1/sync_2 form the metastability chain; prev holds the last
  // synchronized level so the edge compare uses only settled values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_1 <= pin;
      sync_2 <= sync_1;
      prev   <= sync_2;
      rise   <= sync_2 & ~prev;
      fall   <= ~sync_2 & prev;
    end
  end

endmodule

// File: rtl/audio_dac_transmitter.sv
// audio_dac_transmitter: I2S serializer for the codec DAC path.
// Pulls {left,right} frames from a show-ahead FIFO and shifts them
// MSB-first onto aud_dacdat, slaved to the codec BCLK and DAC LRCK.
//   clk, reset        : system clock, synchronous active-high reset
//   aud_bclk          : codec bit clock (async)
//   aud_daclrck       : codec DAC LR clock (async), low = left
//   aud_dacdat        : serial DAC data, registered in clk
//   fifo_q            : show-ahead FIFO data {left, right}
//   fifo_rdempty      : FIFO empty
//   fifo_rdreq        : one-cycle pop strobe, same cycle as fifo_q capture
//   underrun          : one-cycle pulse, left frame start with FIFO empty
//   underrun_count    : saturating underrun count
//   frame_error       : one-cycle pulse, LR edge before a full sample shifted
//   active            : high once aligned to a left-channel frame
//   dbg_state         : current serializer state
//
// Handshake: the FIFO read port is show-ahead, so fifo_q is valid whenever
// fifo_rdempty is low; fifo_rdreq is asserted in exactly the cycle fifo_q
// is captured and acknowledges (pops) that word. No pop ever occurs while
// fifo_rdempty is high or while reset is high.
module audio_dac_transmitter
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = AUDIO_SAMPLE_W,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  aud_bclk,
  input  logic                  aud_daclrck,
  output logic                  aud_dacdat,
  input  logic [2*SAMPLE_W-1:0] fifo_q,
  input  logic                  fifo_rdempty,
  output logic                  fifo_rdreq,
  output logic                  underrun,
  output logic [CNT_W-1:0]      underrun_count,
  output logic                  frame_error,
  output logic                  active,
  output dac_state_t            dbg_state
);

  localparam int BIT_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(SAMPLE_W - 1);

  dac_state_t state;
  dac_state_t state_next;

  logic bclk_fall;
  logic bclk_rise_unused;
  logic lr_fall;
  logic lr_rise;

  logic                  channel;    // 0 = left half, 1 = right half
  logic [2*SAMPLE_W-1:0] frame_reg;
  logic [BIT_W-1:0]      bit_cnt;    // index of the bit last driven
  logic [BIT_W-1:0]      bit_cnt_m1;
  logic [SAMPLE_W-1:0]   cur_sample;

  logic lr_edge;      // LR edge that the current state acts on
  logic lr_abort;     // LR edge cut a channel short
  logic fetch_ok;
  logic fetch_empty;
  logic bit_slot;     // bclk_fall not overridden by an LR edge

  edge_sync u_bclk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (aud_bclk),
    .rise  (bclk_rise_unused),
    .fall  (bclk_fall)
  );

  edge_sync u_lrck_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (aud_daclrck),
    .rise  (lr_rise),
    .fall  (lr_fall)
  );

  // Event decode. A right-channel start is ignored until aligned so the
  // block never begins transmitting in the middle of a stereo frame.
  always_comb begin
    lr_edge     = lr_fall | (lr_rise & (state != WAIT_SYNC));
    lr_abort    = lr_edge & ((state == WAIT_MSB) | (state == SHIFT));
    fetch_ok    = lr_fall & ~fifo_rdempty & ~reset;
    fetch_empty = lr_fall & fifo_rdempty & ~reset;
    // An LR edge in the same cycle as a BCLK fall takes precedence; that
    // fall is not used as a bit slot.
    bit_slot    = bclk_fall & ~lr_edge;
    bit_cnt_m1  = bit_cnt - 1'b1;
    cur_sample  = channel ? frame_reg[SAMPLE_W-1:0]
                          : frame_reg[2*SAMPLE_W-1:SAMPLE_W];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SYNC: if (lr_fall) state_next = WAIT_MSB;
      WAIT_MSB: begin
        if (lr_edge)       state_next = WAIT_MSB;
        else if (bit_slot) state_next = SHIFT;
      end
      SHIFT: begin
        if (lr_edge)                          state_next = WAIT_MSB;
        else if (bit_slot && bit_cnt == '0)   state_next = PAD;
      end
      PAD: if (lr_edge) state_next = WAIT_MSB;
      default: state_next = WAIT_SYNC;
    endcase
  end

  // Output decode.
  always_comb begin
    active     = (state != WAIT_SYNC);
    dbg_state  = state;
    fifo_rdreq = fetch_ok;
  end

  // Datapath: frame capture, shifting, status pulses and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      aud_dacdat     <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
      frame_error    <= 1'b0;
      frame_reg      <= '0;
      channel        <= 1'b0;
      bit_cnt        <= '0;
    end else begin
      underrun    <= fetch_empty;
      frame_error <= lr_abort;

      if (fetch_ok) begin
        frame_reg <= fifo_q;
      end else if (fetch_empty) begin
        frame_reg <= '0;
      end

      if (fetch_empty && (underrun_count != '1)) begin
        underrun_count <= underrun_count + 1'b1;
      end

      if (lr_fall) begin
        channel <= 1'b0;
      end else if (lr_edge) begin
        channel <= 1'b1;
      end

      if (state == WAIT_SYNC) begin
        aud_dacdat <= 1'b0;
      end else if (bit_slot) begin
        case (state)
          WAIT_MSB: begin
            aud_dacdat <= cur_sample[SAMPLE_W-1];
            bit_cnt    <= BIT_MSB;
          end
          SHIFT: begin
            if (bit_cnt == '0) begin
              aud_dacdat <= 1'b0;
            end else begin
              aud_dacdat <= cur_sample[bit_cnt_m1];
              bit_cnt    <= bit_cnt_m1;
            end
          end
          default: aud_dacdat <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_transmitter.sv
module tb_audio_dac_transmitter;
  import audio_pkg::*;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sat_reset = 1'b1;
  always #5 clk = ~clk;

  logic          aud_bclk = 1'b1;
  logic          aud_daclrck = 1'b1;
  logic          aud_dacdat;
  logic [2*W-1:0] fifo_q = '0;
  logic          fifo_rdempty = 1'b1;
  logic          fifo_rdreq;
  logic          underrun;
  logic [15:0]   underrun_count;
  logic          frame_error;
  logic          active;
  dac_state_t    dbg_state;

  logic          sat_dacdat;
  logic          sat_rdreq;
  logic          sat_underrun;
  logic [3:0]    sat_count;
  logic          sat_ferr;
  logic          sat_active;
  dac_state_t    sat_state;
  logic [2*W-1:0] zero_word = '0;
  logic          always_empty = 1'b1;

  audio_dac_transmitter #(.SAMPLE_W(W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(aud_dacdat), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
    .fifo_rdreq(fifo_rdreq), .underrun(underrun), .underrun_count(underrun_count),
    .frame_error(frame_error), .active(active), .dbg_state(dbg_state)
  );

  // Narrow-counter build fed from a permanently empty FIFO.
  audio_dac_transmitter #(.SAMPLE_W(W), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(sat_reset), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(sat_dacdat), .fifo_q(zero_word), .fifo_rdempty(always_empty),
    .fifo_rdreq(sat_rdreq), .underrun(sat_underrun), .underrun_count(sat_count),
    .frame_error(sat_ferr), .active(sat_active), .dbg_state(sat_state)
  );

  int checks = 0;
  int errors = 0;

  // FIFO model and event monitors (single writer of the FIFO signals)
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] push_word;
  int push_cnt = 0;
  int push_done = 0;
  bit pop_pending = 0;
  int n_rdreq = 0;
  int n_bad_rd = 0;
  int n_underrun = 0;
  int n_ferr = 0;
  int n_lr_fall = 0;

  always @(negedge clk) begin
    if (pop_pending) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      pop_pending = 0;
    end
    if (push_cnt != push_done) begin
      exp_q.push_back(push_word);
      push_done = push_cnt;
    end
    if (fifo_rdreq) begin
      n_rdreq++;
      if (fifo_rdempty || reset) n_bad_rd++;
      pop_pending = 1;
    end
    if (underrun) n_underrun++;
    if (frame_error) n_ferr++;
    fifo_rdempty = (exp_q.size() == 0);
    fifo_q = (exp_q.size() > 0) ? exp_q[0] : '0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic push(input logic [2*W-1:0] w);
    @(negedge clk);
    push_word = w;
    push_cnt++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // One BCLK period of 8 clk cycles. The LR pin optionally changes with
  // the BCLK fall; data is sampled 6 clk cycles after the fall.
  task automatic bclk_cycle(input logic new_lr, input bit change_lr,
                            output logic smp, output logic act);
    @(negedge clk);
    aud_bclk = 1'b0;
    if (change_lr) begin
      if (aud_daclrck && !new_lr) n_lr_fall++;
      aud_daclrck = new_lr;
    end
    repeat (4) @(negedge clk);
    aud_bclk = 1'b1;
    repeat (2) @(negedge clk);
    smp = aud_dacdat;
    act = active;
    @(negedge clk);
  endtask

  // Fall k=1 carries the LR edge, falls 2..17 carry MSB..LSB.
  task automatic send_channel(input logic lr, input int nb,
                              output logic [W-1:0] bits, output bit tail_zero,
                              output int ones, output int act_cnt);
    logic s, a;
    bits = '0; tail_zero = 1; ones = 0; act_cnt = 0;
    for (int k = 1; k <= nb; k++) begin
      bclk_cycle(lr, k == 1, s, a);
      if (s) ones++;
      if (a) act_cnt++;
      if (k >= 2 && k <= 17) bits[17-k] = s;
      else if (k >= 18 && s) tail_zero = 0;
    end
  endtask

  task automatic send_frame(input int nb, output logic [W-1:0] lbits,
                            output logic [W-1:0] rbits, output bit tails_ok);
    bit tl, tr;
    int o, a;
    send_channel(1'b0, nb, lbits, tl, o, a);
    send_channel(1'b1, nb, rbits, tr, o, a);
    tails_ok = tl & tr;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    sat_reset = 1'b1;
    repeat (4) @(negedge clk);
    sat_reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (aud_dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat got %b want 0", aud_dacdat); end
    checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got %b want 0", fifo_rdreq); end
    checks++; if (underrun !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", underrun, frame_error); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", underrun_count); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
    checks++; if (dbg_state !== WAIT_SYNC) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, WAIT_SYNC); end
  endtask

  task automatic test_sync_first_rise();
    logic [W-1:0] b;
    bit t;
    int o, a, ones_total, act_total;
    // LRCK and BCLK already toggling while reset is held
    send_channel(1'b1, 20, b, t, o, a);
    send_channel(1'b0, 10, b, t, o, a);
    reset = 1'b0;
    // remainder of the left channel, then a right channel: first edge is a rise
    send_channel(1'b0, 20, b, t, ones_total, act_total);
    send_channel(1'b1, 64, b, t, o, a);
    ones_total += o;
    act_total += a;
    checks++; if (ones_total !== 0) begin errors++; $display("FAIL sync_dacdat_ones got %0d want 0", ones_total); end
    checks++; if (act_total !== 0) begin errors++; $display("FAIL sync_active_samples got %0d want 0", act_total); end
  endtask

  task automatic test_basic();
    logic [W-1:0] lb, rb;
    bit tails;
    int rd0, ur0;
    push(32'hA5A5_3C3C);
    rd0 = n_rdreq; ur0 = n_underrun;
    send_frame(64, lb, rb, tails);
    checks++; if (lb !== 16'b1010_0101_1010_0101) begin errors++; $display("FAIL basic_left got %h want a5a5", lb); end
    checks++; if (rb !== 16'b0011_1100_0011_1100) begin errors++; $display("FAIL basic_right got %h want 3c3c", rb); end
    checks++; if (!tails) begin errors++; $display("FAIL basic_pad got nonzero want zero"); end
    checks++; if (n_rdreq - rd0 !== 1) begin errors++; $display("FAIL basic_rdreq got %0d want 1", n_rdreq - rd0); end
    checks++; if (n_underrun - ur0 !== 0) begin errors++; $display("FAIL basic_underrun got %0d want 0", n_underrun - ur0); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL basic_active got %b want 1", active); end
    checks++; if (sat_count !== 4'(n_lr_fall)) begin errors++; $display("FAIL sat_count_early got %0d want %0d", sat_count, n_lr_fall); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] lb, rb;
    bit tails;
    int rd0;
    push(32'h1357_9BDF);
    push(32'hFEDC_0001);
    rd0 = n_rdreq;
    send_frame(64, lb, rb, tails);
    checks++; if ({lb, rb} !== 32'h1357_9BDF) begin errors++; $display("FAIL b2b_frame0 got %h want 13579bdf", {lb, rb}); end
    send_frame(64, lb, rb, tails);
    checks++; if ({lb, rb} !== 32'hFEDC_0001) begin errors++; $display("FAIL b2b_frame1 got %h want fedc0001", {lb, rb}); end
    checks++; if (!tails) begin errors++; $display("FAIL b2b_pad got nonzero want zero"); end
    checks++; if (n_rdreq - rd0 !== 2) begin errors++; $display("FAIL b2b_rdreq got %0d want 2", n_rdreq - rd0); end
  endtask

  task automatic test_underrun();
    logic [W-1:0] lb, rb;
    bit tails;
    int rd0, ur0, ones;
    reset_dut();
    rd0 = n_rdreq; ur0 = n_underrun; ones = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(64, lb, rb, tails);
      if (lb != 0 || rb != 0 || !tails) ones++;
    end
    checks++; if (n_underrun - ur0 !== 3) begin errors++; $display("FAIL underrun_pulses got %0d want 3", n_underrun - ur0); end
    checks++; if (underrun_count !== 16'd3) begin errors++; $display("FAIL underrun_count got %0d want 3", underrun_count); end
    checks++; if (ones !== 0) begin errors++; $display("FAIL underrun_data got %0d nonzero frames want 0", ones); end
    checks++; if (n_rdreq - rd0 !== 0) begin errors++; $display("FAIL underrun_rdreq got %0d want 0", n_rdreq - rd0); end
    push(32'h8000_7FFF);
    send_frame(64, lb, rb, tails);
    checks++; if (lb !== 16'h8000 || rb !== 16'h7FFF) begin errors++; $display("FAIL refill_frame got %h%h want 80007fff", lb, rb); end
    checks++; if (underrun_count !== 16'd3) begin errors++; $display("FAIL refill_count got %0d want 3", underrun_count); end
  endtask

  task automatic test_short_frames();
    logic [W-1:0] lb, rb;
    logic [2*W-1:0] w0, w1, w2;
    bit tails;
    int rd0, fe0;
    w0 = 32'hB7E1_4D29; w1 = 32'h9C3F_62A8; w2 = 32'hD00D_BEEF;
    push(w0); push(w1); push(w2);
    rd0 = n_rdreq; fe0 = n_ferr;
    send_frame(8, lb, rb, tails);
    checks++; if (lb[15:9] !== w0[31:25] || rb[15:9] !== w0[15:9]) begin errors++; $display("FAIL short0_msbs got %h/%h want %h/%h", lb[15:9], rb[15:9], w0[31:25], w0[15:9]); end
    send_frame(8, lb, rb, tails);
    checks++; if (lb[15:9] !== w1[31:25] || rb[15:9] !== w1[15:9]) begin errors++; $display("FAIL short1_msbs got %h/%h want %h/%h", lb[15:9], rb[15:9], w1[31:25], w1[15:9]); end
    send_frame(64, lb, rb, tails);
    checks++; if ({lb, rb} !== w2) begin errors++; $display("FAIL short_recover got %h want %h", {lb, rb}, w2); end
    checks++; if (n_ferr - fe0 !== 4) begin errors++; $display("FAIL short_frame_error got %0d want 4", n_ferr - fe0); end
    checks++; if (n_rdreq - rd0 !== 3) begin errors++; $display("FAIL short_rdreq got %0d want 3", n_rdreq - rd0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] lb, rb, bits;
    bit tails, t;
    logic s, a;
    int rd0, o, act_n, ones_n;
    push(32'h00FF_F00F);
    push(32'h6C93_1E2D);
    rd0 = n_rdreq;
    // left channel up to the BCLK fall carrying bit 7
    bits = '0;
    for (int k = 1; k <= 10; k++) begin
      bclk_cycle(1'b0, k == 1, s, a);
      bits[17-k] = s;
    end
    checks++; if (bits[15:7] !== 9'b0_0000_0001) begin errors++; $display("FAIL mid_prefix got %b want 000000001", bits[15:7]); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (aud_dacdat !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL mid_reset_out got dat=%b act=%b want 0/0", aud_dacdat, active); end
    @(negedge clk);
    reset = 1'b0;
    ones_n = 0; act_n = 0;
    for (int k = 11; k <= 64; k++) begin
      bclk_cycle(1'b0, 1'b0, s, a);
      if (s) ones_n++;
      if (a) act_n++;
    end
    send_channel(1'b1, 64, bits, t, o, a);
    ones_n += o; act_n += a;
    checks++; if (ones_n !== 0 || act_n !== 0) begin errors++; $display("FAIL mid_idle got ones=%0d act=%0d want 0/0", ones_n, act_n); end
    checks++; if (n_rdreq - rd0 !== 1) begin errors++; $display("FAIL mid_no_extra_pop got %0d want 1", n_rdreq - rd0); end
    send_frame(64, lb, rb, tails);
    checks++; if ({lb, rb} !== 32'h6C93_1E2D) begin errors++; $display("FAIL mid_resume got %h want 6c931e2d", {lb, rb}); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] lb, rb;
    bit tails;
    while (n_lr_fall < 20) send_frame(20, lb, rb, tails);
    checks++; if (sat_count !== 4'd15) begin errors++; $display("FAIL sat_count got %0d want 15", sat_count); end
    checks++; if (n_bad_rd !== 0) begin errors++; $display("FAIL rdreq_when_empty got %0d want 0", n_bad_rd); end
  endtask

  initial begin
    test_reset();
    test_sync_first_rise();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_short_frames();
    test_reset_mid_frame();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
